hamming_channel_error_injector: RTL and testbench

- Sits between the Hamming(15,11) encoder serial output and the decoder serial input.
- Passes the 15-bit serial codeword stream through with one registered cycle of latency.
- Inverts a programmable bit position in selected frames, so correction can be exercised on silicon and in simulation.
- Tracks frame boundaries, paces injection every Nth frame, and counts injected bits.

---
 rtl/hamming_chan_pkg.sv | 18 +
 rtl/hamming_channel_error_injector_frame_tracker.sv | 64 ++++++
 rtl/hamming_channel_error_injector.sv | 122 ++++++++++++
 tb/tb_hamming_channel_error_injector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_chan_pkg.sv
// Shared constants, state encoding and position range check for the Hamming(15,11)
// channel error injector.
package hamming_chan_pkg;

  localparam int FRAME_LEN = 15;
  localparam int POS_W     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  // Positions are 1-based; 0 and anything beyond the frame length mean "no injection".
  function automatic logic pos_in_range(input logic [POS_W-1:0] pos, input int unsigned frame_len);
    return (pos != '0) && (32'(pos) <= frame_len);
  endfunction

endpackage

// File: rtl/hamming_channel_error_injector_frame_tracker.sv
// Frame boundary tracker: IDLE/FRAME state, bit position within the frame, resync on
// an early SOF and a registered one-cycle frame_err pulse.
module hamming_frame_tracker
  import hamming_chan_pkg::*;
#(
  parameter int LEN = FRAME_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             sof_i,
  output logic             start_o,
  output logic             in_frame_o,
  output logic [POS_W-1:0] pos_o,
  output logic             frame_err_o
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LEN);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             frame_err_q, frame_err_d;

  // pos_q holds the position the next in-frame bit will occupy.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    frame_err_d = 1'b0;
    start_o     = valid_i & sof_i;
    in_frame_o  = valid_i & (sof_i | (state_q == FRAME));
    pos_o       = sof_i ? POS_W'(1) : pos_q;
    if (valid_i) begin
      if (sof_i) begin
        frame_err_d = (state_q == FRAME);
        state_d     = FRAME;
        pos_d       = POS_W'(2);
      end else if (state_q == FRAME) begin
        if (pos_q == LAST_POS) begin
          state_d = IDLE;
          pos_d   = '0;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err_o = frame_err_q;

endmodule

// File: rtl/hamming_channel_error_injector.sv
// Serial channel error injector between the Hamming(15,11) encoder and decoder.
// Define HAMMING_INJ_DOUBLE_EN to add inj_pos2 for a second flipped position per frame.
module hamming_channel_error_injector #(
  parameter int FRAME_LEN = hamming_chan_pkg::FRAME_LEN,
  parameter int CNT_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              bit_in_valid,
  input  logic                              bit_in,
  input  logic                              sof_in,
  input  logic                              inj_en,
  input  logic [hamming_chan_pkg::POS_W-1:0] inj_pos,
  input  logic [hamming_chan_pkg::POS_W-1:0] inj_every,
`ifdef HAMMING_INJ_DOUBLE_EN
  input  logic [hamming_chan_pkg::POS_W-1:0] inj_pos2,
`endif
  output logic                              bit_out,
  output logic                              bit_out_valid,
  output logic                              sof_out,
  output logic                              flipped,
  output logic                              frame_err,
  output logic [CNT_W-1:0]                  inj_count
);

  import hamming_chan_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             start, in_frame;
  logic [POS_W-1:0] beat_pos;

  logic [POS_W-1:0] pos_l_q, pos_l_d;
  logic [POS_W-1:0] period_q, period_d;
  logic             armed_q, armed_d;
  logic             bit_out_q, bit_out_d;
  logic             valid_q, sof_q, flipped_q;
  logic             flip;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef HAMMING_INJ_DOUBLE_EN
  logic [POS_W-1:0] pos2_l_q, pos2_l_d;
  logic             armed2_q, armed2_d;
`endif

  hamming_frame_tracker #(
    .LEN(FRAME_LEN)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (bit_in_valid),
    .sof_i      (sof_in),
    .start_o    (start),
    .in_frame_o (in_frame),
    .pos_o      (beat_pos),
    .frame_err_o(frame_err)
  );

  // On a SOF beat the _d values are the freshly latched config, so the SOF bit itself
  // (position 1) can be flipped without waiting for the registers.
  always_comb begin
    pos_l_d  = pos_l_q;
    armed_d  = armed_q;
    period_d = period_q;
`ifdef HAMMING_INJ_DOUBLE_EN
    pos2_l_d = pos2_l_q;
    armed2_d = armed2_q;
`endif
    if (start) begin
      pos_l_d  = inj_pos;
      armed_d  = inj_en & (period_q == '0) & pos_in_range(inj_pos, FRAME_LEN);
      period_d = (period_q >= inj_every) ? '0 : period_q + 1'b1;
`ifdef HAMMING_INJ_DOUBLE_EN
      pos2_l_d = inj_pos2;
      armed2_d = inj_en & (period_q == '0) & pos_in_range(inj_pos2, FRAME_LEN)
               & (inj_pos2 != inj_pos);
`endif
    end
    flip = in_frame & armed_d & (beat_pos == pos_l_d);
`ifdef HAMMING_INJ_DOUBLE_EN
    flip = flip | (in_frame & armed2_d & (beat_pos == pos2_l_d));
`endif
    bit_out_d = bit_in_valid ? (bit_in ^ flip) : bit_out_q;
    cnt_d     = (flip && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_l_q   <= '0;
      period_q  <= '0;
      armed_q   <= 1'b0;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
      sof_q     <= 1'b0;
      flipped_q <= 1'b0;
      cnt_q     <= '0;
`ifdef HAMMING_INJ_DOUBLE_EN
      pos2_l_q  <= '0;
      armed2_q  <= 1'b0;
`endif
    end else begin
      pos_l_q   <= pos_l_d;
      period_q  <= period_d;
      armed_q   <= armed_d;
      bit_out_q <= bit_out_d;
      valid_q   <= bit_in_valid;
      sof_q     <= start;
      flipped_q <= flip;
      cnt_q     <= cnt_d;
`ifdef HAMMING_INJ_DOUBLE_EN
      pos2_l_q  <= pos2_l_d;
      armed2_q  <= armed2_d;
`endif
    end
  end

  assign bit_out       = bit_out_q;
  assign bit_out_valid = valid_q;
  assign sof_out       = sof_q;
  assign flipped       = flipped_q;
  assign inj_count     = cnt_q;

endmodule

// File: tb/tb_hamming_channel_error_injector.sv
// Directed bench for hamming_channel_error_injector: frames are sent MSB-first and the
// registered output stream, flip mask, framing pulses and injection count are checked.
module tb_hamming_channel_error_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in_valid, bit_in, sof_in, inj_en;
  logic [3:0] inj_pos, inj_every;
`ifdef HAMMING_INJ_DOUBLE_EN
  logic [3:0] inj_pos2;
`endif
  logic       bit_out, bit_out_valid, sof_out, flipped, frame_err;
  logic [7:0] inj_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  int frame_no = 0;

  hamming_channel_error_injector #(
    .FRAME_LEN(15),
    .CNT_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in_valid (bit_in_valid),
    .bit_in       (bit_in),
    .sof_in       (sof_in),
    .inj_en       (inj_en),
    .inj_pos      (inj_pos),
    .inj_every    (inj_every),
`ifdef HAMMING_INJ_DOUBLE_EN
    .inj_pos2     (inj_pos2),
`endif
    .bit_out      (bit_out),
    .bit_out_valid(bit_out_valid),
    .sof_out      (sof_out),
    .flipped      (flipped),
    .frame_err    (frame_err),
    .inj_count    (inj_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic beat(input logic v, input logic b, input logic s);
    bit_in_valid = v;
    bit_in       = b;
    sof_in       = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Sends the first n bits of cw; fp/fp2 are the hand-picked positions expected to flip.
  task automatic send_frame(input logic [14:0] cw, input int n, input int fp, input int fp2,
                            input bit err_first, input bit gaps, input bit scramble,
                            input bit quiet);
    logic [14:0] got_w, exp_w, got_f, exp_f, got_s, exp_s, got_e, exp_e;
    logic        exp_bit, hit, b;
    logic [3:0]  sv_pos, sv_every;
    logic        sv_en;
    int          vcnt;
    bit          gap_bad;
    got_w = '0; exp_w = '0; got_f = '0; exp_f = '0; got_s = '0; got_e = '0;
    vcnt = 0; gap_bad = 1'b0;
    sv_pos = inj_pos; sv_every = inj_every; sv_en = inj_en;
    for (int p = 1; p <= n; p++) begin
      b       = cw[15-p];
      hit     = (p == fp) || (p == fp2);
      exp_bit = b ^ hit;
      beat(1'b1, b, p == 1);
      got_w = {got_w[13:0], bit_out};
      got_f = {got_f[13:0], flipped};
      got_s = {got_s[13:0], sof_out};
      got_e = {got_e[13:0], frame_err};
      vcnt += int'(bit_out_valid);
      exp_w = {exp_w[13:0], exp_bit};
      exp_f = {exp_f[13:0], hit};
      if (hit && exp_cnt < 255) exp_cnt++;
      if (scramble && p == 1) begin
        inj_pos = 4'd9; inj_en = 1'b0; inj_every = 4'd5;
      end
      if (gaps) begin
        beat(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if (bit_out !== exp_bit || bit_out_valid !== 1'b0 || flipped !== 1'b0 ||
            sof_out !== 1'b0 || frame_err !== 1'b0) gap_bad = 1'b1;
      end
    end
    inj_pos = sv_pos; inj_every = sv_every; inj_en = sv_en;
    bit_in_valid = 1'b0; sof_in = 1'b0;
    exp_s = 15'(1) << (n - 1);
    exp_e = err_first ? exp_s : 15'd0;
    chk("frame_out", 32'(got_w), 32'(exp_w));
    chk("flip_mask", 32'(got_f), 32'(exp_f));
    chk("sof_mask", 32'(got_s), 32'(exp_s));
    chk("err_mask", 32'(got_e), 32'(exp_e));
    chk("valid_cnt", 32'(vcnt), 32'(n));
    chk("inj_count", 32'(inj_count), 32'(exp_cnt));
    if (gaps) chk("gap_hold", 32'(gap_bad), 32'd0);
    if (!quiet)
      $display("frame %0d cw=%h n=%0d out=%h flips=%h cnt=%0d",
               frame_no, cw, n, got_w, got_f, inj_count);
    frame_no++;
  endtask

  initial begin
    rst = 1'b1; bit_in_valid = 1'b0; bit_in = 1'b0; sof_in = 1'b0;
    inj_en = 1'b0; inj_pos = 4'd0; inj_every = 4'd0;
`ifdef HAMMING_INJ_DOUBLE_EN
    inj_pos2 = 4'd0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_bit_out", 32'(bit_out), 32'd0);
    chk("rst_valid", 32'(bit_out_valid), 32'd0);
    chk("rst_sof", 32'(sof_out), 32'd0);
    chk("rst_flipped", 32'(flipped), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_count", 32'(inj_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Pass-through
    send_frame(15'h3A5C, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single injection at position 3, two back-to-back frames
    inj_en = 1'b1; inj_pos = 4'd3; inj_every = 4'd0;
    send_frame(15'h3A5C, 15, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h1234, 15, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Pacing: one frame in three, frames 0 and 3 corrupted
    inj_every = 4'd2;
    send_frame(15'h5555, 15, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h2AAA, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h7FFF, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h0000, 15, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h4321, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h0F0F, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Boundary positions
    inj_every = 4'd0; inj_pos = 4'd0;
    send_frame(15'h3A5C, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    inj_pos = 4'd15;
    send_frame(15'h3A5C, 15, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Valid bit in IDLE without sof: unmodified, frame_err pulse
    beat(1'b1, 1'b1, 1'b0);
    chk("idle_bit", 32'(bit_out), 32'd1);
    chk("idle_flipped", 32'(flipped), 32'd0);
    chk("idle_frame_err", 32'(frame_err), 32'd1);
    chk("idle_sof", 32'(sof_out), 32'd0);
    beat(1'b0, 1'b0, 1'b0);
    chk("idle_err_pulse", 32'(frame_err), 32'd0);
    chk("idle_count", 32'(inj_count), 32'(exp_cnt));
    $display("idle beat bit=1 frame_err seen cnt=%0d", inj_count);

    // Resync: new sof on position 7 of a partial frame
    inj_pos = 4'd3;
    send_frame(15'h6B2D, 6, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h1C3E, 15, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stalls every other cycle, config scrambled mid-frame
    send_frame(15'h3A5C, 15, 3, 0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset mid-frame restarts pacing at period index 0
    inj_every = 4'd1;
    send_frame(15'h2468, 5, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    beat(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    exp_cnt = 0;
    chk("mrst_bit_out", 32'(bit_out), 32'd0);
    chk("mrst_valid", 32'(bit_out_valid), 32'd0);
    chk("mrst_sof", 32'(sof_out), 32'd0);
    chk("mrst_flipped", 32'(flipped), 32'd0);
    chk("mrst_frame_err", 32'(frame_err), 32'd0);
    chk("mrst_count", 32'(inj_count), 32'd0);
    $display("mid-frame reset cnt=%0d", inj_count);
    bit_in_valid = 1'b0;
    send_frame(15'h3A5C, 15, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(15'h3A5C, 15, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef HAMMING_INJ_DOUBLE_EN
    inj_every = 4'd0; inj_pos = 4'd3; inj_pos2 = 4'd9;
    send_frame(15'h3A5C, 15, 3, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    inj_pos2 = 4'd3;
    send_frame(15'h3A5C, 15, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    inj_pos2 = 4'd0;
`endif

    // Saturation of the 8-bit counter
    inj_every = 4'd0; inj_pos = 4'd1;
    for (int k = 0; k < 256; k++)
      send_frame(15'h3A5C, 15, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("count_saturated", 32'(inj_count), 32'd255);
    $display("saturation run done cnt=%0d", inj_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
